// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared definitions for the hazard-light pattern:
//   hz_state_t  - pattern states, encoded as the LED pattern they drive
//   MODE_*      - mode select constants
//   next_state  - pattern transition rule, reusable by any block that
//                 needs to predict or drive the hazard pattern
package hazard_pkg;

   typedef enum logic [2:0] {
      ST_OUTSIDE = 3'b101,
      ST_CENTER  = 3'b010,
      ST_LEFT    = 3'b100,
      ST_RIGHT   = 3'b001
   } hz_state_t;

   localparam logic [1:0] MODE_CALM  = 2'b00;
   localparam logic [1:0] MODE_RIGHT = 2'b01;
   localparam logic [1:0] MODE_LEFT  = 2'b10;
   localparam logic [1:0] MODE_BAD   = 2'b11;

   // The illegal mode falls into the calm branch on purpose.
   // OUTSIDE always enters a sweep from the end opposite its direction.
   function automatic hz_state_t next_state(input hz_state_t state,
                                            input logic [1:0] mode);
      hz_state_t nxt;
      nxt = ST_OUTSIDE;
      case (mode)
         MODE_RIGHT: begin
            case (state)
               ST_LEFT:   nxt = ST_CENTER;
               ST_CENTER: nxt = ST_RIGHT;
               ST_RIGHT:  nxt = ST_LEFT;
               default:   nxt = ST_LEFT;
            endcase
         end
         MODE_LEFT: begin
            case (state)
               ST_RIGHT:  nxt = ST_CENTER;
               ST_CENTER: nxt = ST_LEFT;
               ST_LEFT:   nxt = ST_RIGHT;
               default:   nxt = ST_RIGHT;
            endcase
         end
         default: begin
            nxt = (state == ST_OUTSIDE) ? ST_CENTER : ST_OUTSIDE;
         end
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/tick_divider.sv
// tick_divider
// Free-running step-rate divider. Counts 0..TICK_DIV-1 and wraps.
//   clk    in  system clock
//   reset  in  synchronous active-low reset (count -> 0)
//   hold   in  freeze the count while 1
//   wrap   out 1 when count is at TICK_DIV-1 and hold is 0
module tick_divider #(
   parameter int TICK_DIV = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic hold,
   output logic wrap
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count;

   assign wrap = ~hold & (count == LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (!hold) begin
         if (count == LAST) count <= '0;
         else               count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer
// Paced controller for the three-LED hazard pattern.
//   clk       in   system clock
//   reset     in   synchronous active-low reset
//   mode[1:0] in   00 calm, 01 sweep-right, 10 sweep-left, 11 illegal
//   pause     in   level; freezes automatic stepping
//   step      in   manual advance on its rising edge, honoured only while paused
//   led[2:0]  out  current pattern (the state register itself)
//   tick      out  1 in the cycle a new led value first appears
//   err       out  1 in the cycle after an advance taken with mode 11
//   step_cnt  out  advances taken, wraps 255 -> 0
//
// Control semantics: there is no handshake. An advance happens on any edge
// where adv=1; adv is the divider wrap while unpaused, or a step rising edge
// while paused. Step edges seen while unpaused are dropped, never queued.
module hazard_sequencer
   import hazard_pkg::*;
#(
   parameter int TICK_DIV = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] mode,
   input  logic       pause,
   input  logic       step,
   output logic [2:0] led,
   output logic       tick,
   output logic       err,
   output logic [7:0] step_cnt
);

   hz_state_t state_q;
   logic      step_q;
   logic      step_rise;
   logic      wrap;
   logic      adv;

   // The divider sees pause as hold, so wrap is already gated by ~pause.
   tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
      .clk   (clk),
      .reset (reset),
      .hold  (pause),
      .wrap  (wrap)
   );

   assign step_rise = step & ~step_q;
   assign adv       = wrap | (pause & step_rise);

   // led is driven straight from the state register, so it doubles as the
   // observable FSM state.
   assign led = state_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_OUTSIDE;
         step_q   <= 1'b0;
         tick     <= 1'b0;
         err      <= 1'b0;
         step_cnt <= 8'd0;
      end else begin
         step_q <= step;
         if (adv) begin
            state_q  <= next_state(state_q, mode);
            step_cnt <= step_cnt + 8'd1;
            tick     <= 1'b1;
            err      <= (mode == MODE_BAD);
         end else begin
            tick <= 1'b0;
            err  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer
// Directed bench for hazard_sequencer with TICK_DIV=8. Expected values are
// hand-derived constants. Inputs change 1 time unit after a posedge and
// outputs are sampled at that same point, i.e. after the edge has settled.
module tb_hazard_sequencer;

   logic       clk;
   logic       reset;
   logic [1:0] mode;
   logic       pause;
   logic       step;
   logic [2:0] led;
   logic       tick;
   logic       err;
   logic [7:0] step_cnt;

   int n_checks;
   int n_errors;

   localparam logic [2:0] L_OUT = 3'b101;
   localparam logic [2:0] L_CEN = 3'b010;
   localparam logic [2:0] L_LFT = 3'b100;
   localparam logic [2:0] L_RGT = 3'b001;

   hazard_sequencer #(.TICK_DIV(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .mode     (mode),
      .pause    (pause),
      .step     (step),
      .led      (led),
      .tick     (tick),
      .err      (err),
      .step_cnt (step_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      cyc(2);
      reset = 1'b1;
   endtask

   // one manual step: rising edge, then low again
   task automatic pulse_step();
      step = 1'b1;
      cyc(1);
      step = 1'b0;
      cyc(1);
   endtask

   // checker
   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   logic [2:0] exp_right [4];
   logic [2:0] exp_led;
   logic       exp_tick;

   initial begin
      n_checks = 0;
      n_errors = 0;
      mode  = 2'b00;
      pause = 1'b0;
      step  = 1'b0;
      reset = 1'b1;
      exp_right[0] = L_LFT;
      exp_right[1] = L_CEN;
      exp_right[2] = L_RGT;
      exp_right[3] = L_LFT;
      cyc(1);

      // reset state
      reset = 1'b0;
      cyc(2);
      check("rst_led", 8'(led), 8'(L_OUT));
      check("rst_tick", 8'(tick), 8'd0);
      check("rst_err", 8'(err), 8'd0);
      check("rst_cnt", step_cnt, 8'd0);
      reset = 1'b1;

      // calm mode: advances at edges 8 and 16 after release
      for (int c = 1; c <= 16; c++) begin
         cyc(1);
         exp_led  = (c < 8) ? L_OUT : (c < 16) ? L_CEN : L_OUT;
         exp_tick = (c == 8) || (c == 16);
         check("calm_led", 8'(led), 8'(exp_led));
         check("calm_tick", 8'(tick), 8'(exp_tick));
      end
      check("calm_cnt", step_cnt, 8'd2);

      // sweep-right: four advances from reset
      do_reset();
      mode = 2'b01;
      for (int k = 0; k < 4; k++) begin
         cyc(7);
         check("sr_hold", 8'(tick), 8'd0);
         cyc(1);
         check("sr_led", 8'(led), 8'(exp_right[k]));
         check("sr_tick", 8'(tick), 8'd1);
         check("sr_err", 8'(err), 8'd0);
      end
      check("sr_cnt", step_cnt, 8'd4);

      // switch to sweep-left mid-interval: no change before the boundary
      cyc(4);
      mode = 2'b10;
      check("sl_nochg", 8'(led), 8'(L_LFT));
      cyc(3);
      check("sl_nochg2", 8'(led), 8'(L_LFT));
      cyc(1);
      check("sl_led", 8'(led), 8'(L_RGT));
      check("sl_tick", 8'(tick), 8'd1);

      // pause while count sits at 7
      cyc(7);
      pause = 1'b1;
      for (int c = 0; c < 20; c++) begin
         cyc(1);
         check("pz_led", 8'(led), 8'(L_RGT));
         check("pz_tick", 8'(tick), 8'd0);
      end
      pause = 1'b0;
      cyc(1);
      check("pz_rel_led", 8'(led), 8'(L_CEN));
      check("pz_rel_tick", 8'(tick), 8'd1);
      check("pz_rel_cnt", step_cnt, 8'd6);
      cyc(7);
      check("pz_after", 8'(led), 8'(L_CEN));
      cyc(1);
      check("pz_next", 8'(led), 8'(L_LFT));

      // manual steps while paused (count frozen at 0)
      pause = 1'b1;
      step  = 1'b1;
      cyc(1);
      check("ms1_led", 8'(led), 8'(L_RGT));
      check("ms1_tick", 8'(tick), 8'd1);
      cyc(4);
      check("ms_held_led", 8'(led), 8'(L_RGT));
      check("ms_held_tick", 8'(tick), 8'd0);
      step = 1'b0;
      cyc(1);
      step = 1'b1;
      cyc(1);
      check("ms2_led", 8'(led), 8'(L_CEN));
      check("ms2_tick", 8'(tick), 8'd1);
      check("ms_cnt", step_cnt, 8'd9);
      step  = 1'b0;
      pause = 1'b0;
      // step while unpaused must be ignored
      cyc(1);
      step = 1'b1;
      cyc(1);
      check("up_step_led", 8'(led), 8'(L_CEN));
      check("up_step_tick", 8'(tick), 8'd0);
      step = 1'b0;
      cyc(5);
      check("up_step_hold", 8'(led), 8'(L_CEN));
      cyc(1);
      check("up_auto_led", 8'(led), 8'(L_LFT));
      check("up_auto_cnt", step_cnt, 8'd10);

      // illegal mode from LEFT
      mode = 2'b11;
      cyc(8);
      check("bad_led", 8'(led), 8'(L_OUT));
      check("bad_err", 8'(err), 8'd1);
      check("bad_tick", 8'(tick), 8'd1);
      cyc(1);
      check("bad_err_clr", 8'(err), 8'd0);

      // step_cnt wrap after 256 manual advances in calm mode
      do_reset();
      mode  = 2'b00;
      pause = 1'b1;
      for (int i = 0; i < 255; i++) pulse_step();
      check("wrap_255", step_cnt, 8'd255);
      check("wrap_led_odd", 8'(led), 8'(L_CEN));
      pulse_step();
      check("wrap_0", step_cnt, 8'd0);
      check("wrap_led", 8'(led), 8'(L_OUT));

      // reset coinciding with an advance while in LEFT
      pause = 1'b0;
      do_reset();
      mode = 2'b01;
      cyc(8);
      check("rs_left", 8'(led), 8'(L_LFT));
      cyc(7);
      reset = 1'b0;
      cyc(1);
      check("rs_led", 8'(led), 8'(L_OUT));
      check("rs_cnt", step_cnt, 8'd0);
      check("rs_tick", 8'(tick), 8'd0);
      reset = 1'b1;
      cyc(7);
      check("rs_after", 8'(led), 8'(L_OUT));
      cyc(1);
      check("rs_first", 8'(led), 8'(L_LFT));

      // report
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
